// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA/DVI raster timing generator. Issues pixel
//                requests ahead of the output stage so a source with
//                SRC_LAT enabled cycles of latency can supply colour.
//                Colour and delayed timing are registered together.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int CW       = 10,
    parameter int SRC_LAT  = 1
) (
    input  logic           dclk,
    input  logic           clr,
    input  logic           ce,
    output logic           px_req,
    output logic [CW-1:0]  px_x,
    output logic [CW-1:0]  px_y,
    input  logic [R_W-1:0] i_red,
    input  logic [G_W-1:0] i_green,
    input  logic [B_W-1:0] i_blue,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [R_W-1:0] red,
    output logic [G_W-1:0] green,
    output logic [B_W-1:0] blue,
    output logic           line_start,
    output logic           frame_start
);

    localparam int C_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int C_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int C_H_START = H_SYNC + H_BP;
    localparam int C_H_END   = C_H_START + H_ACTIVE;
    localparam int C_V_START = V_SYNC + V_BP;
    localparam int C_V_END   = C_V_START + V_ACTIVE;

    localparam logic [CW-1:0] C_H_LAST = CW'(C_H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST = CW'(C_V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_OFS  = CW'(C_H_START);
    localparam logic [CW-1:0] C_V_OFS  = CW'(C_V_START);

    // Timing tap bit positions inside one pipeline stage
    localparam int C_B_HS   = 4;
    localparam int C_B_VS   = 3;
    localparam int C_B_ACT  = 2;
    localparam int C_B_LINE = 1;
    localparam int C_B_FRM  = 0;

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic [31:0]   w_hc_ext;
    logic [31:0]   w_vc_ext;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_active;
    logic [4:0]    w_tap;
    logic [4:0]    w_dly;
    logic [4:0]    r_pipe [SRC_LAT];

    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;
    logic [R_W-1:0] r_red;
    logic [G_W-1:0] r_green;
    logic [B_W-1:0] r_blue;
    logic           r_line_start;
    logic           r_frame_start;

    // Raster position counters; vertical advances on the horizontal wrap
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (ce) begin
            if (r_hc == C_H_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == C_V_LAST) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    // Region decode is done on 32-bit copies so region ends equal to 2**CW are safe
    assign w_hc_ext = 32'(r_hc);
    assign w_vc_ext = 32'(r_vc);
    assign w_h_act  = (w_hc_ext >= 32'(C_H_START)) && (w_hc_ext < 32'(C_H_END));
    assign w_v_act  = (w_vc_ext >= 32'(C_V_START)) && (w_vc_ext < 32'(C_V_END));
    assign w_active = w_h_act && w_v_act;

    assign px_req = w_active;
    assign px_x   = w_active ? (r_hc - C_H_OFS) : '0;
    assign px_y   = w_active ? (r_vc - C_V_OFS) : '0;

    assign w_tap[C_B_HS]   = w_hc_ext < 32'(H_SYNC);
    assign w_tap[C_B_VS]   = w_vc_ext < 32'(V_SYNC);
    assign w_tap[C_B_ACT]  = w_active;
    assign w_tap[C_B_LINE] = (r_hc == '0);
    assign w_tap[C_B_FRM]  = (r_hc == '0) && (r_vc == '0);

    // First delay stage captures the current position's timing flags
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            r_pipe[0] <= '0;
        end else if (ce) begin
            r_pipe[0] <= w_tap;
        end
    end

    // Remaining delay stages match the pixel source latency
    for (genvar gi = 1; gi < SRC_LAT; gi++) begin : g_pipe
        // Shift one stage forward on each enabled cycle
        always_ff @(posedge dclk or posedge clr) begin
            if (clr) begin
                r_pipe[gi] <= '0;
            end else if (ce) begin
                r_pipe[gi] <= r_pipe[gi-1];
            end
        end
    end

    assign w_dly = r_pipe[SRC_LAT-1];

    // Output stage: delayed timing registered together with the returned colour
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_hsync       <= w_dly[C_B_HS] ? HS_POL : ~HS_POL;
            r_vsync       <= w_dly[C_B_VS] ? VS_POL : ~VS_POL;
            r_de          <= w_dly[C_B_ACT];
            r_red         <= w_dly[C_B_ACT] ? i_red   : '0;
            r_green       <= w_dly[C_B_ACT] ? i_green : '0;
            r_blue        <= w_dly[C_B_ACT] ? i_blue  : '0;
            r_line_start  <= w_dly[C_B_LINE];
            r_frame_start <= w_dly[C_B_FRM];
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
